uart_rx_packet_assembler: RTL and testbench
===========================================

// Module: uart_rx_packet_assembler
// PURPOSE
//  Downstream consumer of the UART/CRC receive path. Takes the per-byte stream (rx_data_out,
//  rx_ready_out, crc_valid_out), frames it into length-prefixed packets, and buffers one packet.
//  A packet is released on a valid/ready byte stream only if every byte passed CRC.
//  Packets with a CRC failure, a bad length or an inter-byte timeout are dropped and counted.
// PARAMETERS
//  MAX_LEN      16      maximum payload bytes per packet (buffer depth), 1..255
//  TIMEOUT_CYC  100000  max clk cycles between consecutive bytes inside a packet, >=2
// PORTS
//  clk         in   1   system clock; all logic is on the rising edge
//  reset       in   1   synchronous, active-low reset (0 = reset)
//  rx_data     in   8   received byte, qualified by rx_ready
//  rx_ready    in   1   one-cycle strobe: rx_data/crc_valid are valid this cycle
//  crc_valid   in   1   CRC status for the byte strobed this cycle (1 = good)
//  m_data      out  8   output payload byte
//  m_valid     out  1   m_data is valid; held until accepted
//  m_last      out  1   m_data is the final payload byte of the packet
//  m_ready     in   1   sink accepts m_data when m_valid && m_ready
//  pkt_good    out  1   one-cycle pulse: packet fully received and CRC-clean
//  pkt_drop    out  1   one-cycle pulse: packet discarded (CRC, length or timeout)
//  overrun     out  1   one-cycle pulse: byte arrived during DRAIN and was discarded
//  drop_count  out  16  packets dropped since reset; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): state=IDLE, all outputs 0, drop_count=0, buffer pointers 0.
//   A reset mid-packet or mid-drain discards the packet and generates no pulse.
//  FSM IDLE -> COLLECT -> DRAIN -> IDLE:
//   IDLE: a byte strobe is the header, where len=rx_data.
//    len==0, len>MAX_LEN, or crc_valid==0 -> pkt_drop, drop_count++, stay IDLE.
//    Otherwise latch len, wr_ptr=0, clear bad flag and timer, go to COLLECT.
//   COLLECT: each strobe writes buf[wr_ptr], wr_ptr++, and the timer restarts at 0.
//    crc_valid==0 sets the sticky bad flag; the byte is still stored.
//    The timer increments on every cycle without a strobe. At timer==TIMEOUT_CYC-1: pkt_drop, go to IDLE.
//    On the strobe of byte len-1: if bad (including the current byte) -> pkt_drop, go to IDLE;
//    else -> pkt_good, rd_ptr=0, go to DRAIN. The pulse occurs in the cycle after the strobe.
//   DRAIN: m_valid=1, m_data=buf[rd_ptr], m_last=(rd_ptr==len-1).
//    On a handshake rd_ptr++; the handshake on m_last -> IDLE, and m_valid=0 in the next cycle.
//    m_data/m_last stay stable while m_valid && !m_ready.
//    A strobe during DRAIN: the byte is discarded and overrun pulses. Framing is lost, so the upstream side must pace packets.
//  Latency: a strobe of the last byte at cycle t -> pkt_good and m_valid with buf[0] at t+1.
//   Throughput is up to 1 byte/cycle out.
//  drop_count increments on every pkt_drop and holds at 16'hFFFF.
//  pkt_good, pkt_drop and overrun are mutually exclusive. They are registered outputs.
//  A strobe coincident with timeout expiry: the timeout wins, the packet drops, and the byte is ignored.
//  len==MAX_LEN fills the buffer exactly. The pointer width is $clog2(MAX_LEN+1). There is no wrap.
// STRUCTURE
//  Shared include uart_pkt_defs.vh contains the state encodings (IDLE/COLLECT/DRAIN = 2'd0/1/2),
//   the default MAX_LEN and TIMEOUT_CYC, and the DROP_CNT_W=16 constant.
//  Sub-module uart_pkt_timer contains the inter-byte timeout counter (clear, enable, expire).
//   The buffer is an inferred register array inside this module.
// TESTING
//  1: Header 8'd3, then 8'hA1/8'hB2/8'hC3 with crc_valid=1, m_ready=1 -> pkt_good once;
//   A1, B2, C3 on consecutive cycles; m_last only on C3.
//  2: Same packet with crc_valid=0 on byte 2 -> pkt_drop, drop_count=1, m_valid never asserted.
//  3: Header 8'd0, then header MAX_LEN+1 -> two pkt_drop pulses, drop_count=2, FSM stays IDLE.
//  4: Header 8'd2, one byte, then idle TIMEOUT_CYC cycles -> pkt_drop. The next header 8'd1
//   plus 8'h55 -> pkt_good, and 55 is output with m_last=1.
//  5: MAX_LEN-byte packet with m_ready toggling 1/0; strobe a byte mid-drain ->
//   every byte is delivered once and in order, data stays stable while stalled, and overrun pulses once.
//  6: Assert reset mid-COLLECT and mid-DRAIN -> all outputs 0 the next cycle, no pulses,
//   drop_count=0; a new packet then completes normally.

Source files
------------

// File: rtl/uart_rx_packet_assembler_pkg.sv
// Shared definitions for the UART receive packet assembler: FSM states,
// default sizing and the saturating drop counter helper.
package uart_rx_packet_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    localparam int unsigned DEF_MAX_LEN     = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 100000;
    localparam int unsigned DROP_CNT_W      = 16;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_packet_assembler_timer.sv
// Inter-byte timeout counter: cleared on each byte, counts idle cycles,
// and holds at the expiry value so it never wraps.
module uart_pkt_timer
    import uart_rx_packet_assembler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == LAST);

endmodule

// File: rtl/uart_rx_packet_assembler.sv
// Frames the per-byte UART/CRC receive stream into length-prefixed packets,
// buffers one packet and releases it on a valid/ready stream only if CRC-clean.
module uart_rx_packet_assembler
    import uart_rx_packet_assembler_pkg::*;
#(
    parameter int unsigned MAX_LEN     = DEF_MAX_LEN,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  crc_valid,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  pkt_good,
    output logic                  pkt_drop,
    output logic                  overrun,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int unsigned PW        = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_e                  state_q, state_d;
    logic [7:0]              len_q, len_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic                    bad_q, bad_d;
    logic                    pkt_good_q, pkt_good_d;
    logic                    pkt_drop_q, pkt_drop_d;
    logic                    overrun_q, overrun_d;
    logic [DROP_CNT_W-1:0]   drop_count_q, drop_count_d;
    logic [7:0]              buf_q [MAX_LEN];
    logic [7:0]              buf_d [MAX_LEN];
    logic                    buf_we;
    logic [7:0]              rd_byte;
    logic                    wr_last;
    logic                    rd_last;
    logic                    timer_clear;
    logic                    timer_en;
    logic                    timer_expire;

    uart_pkt_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (timer_expire)
    );

    assign wr_last = (8'(wr_ptr_q) == (len_q - 8'd1));
    assign rd_last = (8'(rd_ptr_q) == (len_q - 8'd1));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        bad_d       = bad_q;
        pkt_good_d  = 1'b0;
        pkt_drop_d  = 1'b0;
        overrun_d   = 1'b0;
        buf_we      = 1'b0;
        timer_clear = 1'b1;
        timer_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_ready) begin
                    if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B) || !crc_valid) begin
                        pkt_drop_d = 1'b1;
                    end else begin
                        len_d    = rx_data;
                        wr_ptr_d = '0;
                        bad_d    = 1'b0;
                        state_d  = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                timer_clear = rx_ready;
                timer_en    = !rx_ready;
                // Expiry takes priority over a coincident byte, which is then ignored.
                if (timer_expire) begin
                    pkt_drop_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (rx_ready) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    bad_d    = bad_q | ~crc_valid;
                    if (wr_last) begin
                        if (bad_q || !crc_valid) begin
                            pkt_drop_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            pkt_good_d = 1'b1;
                            rd_ptr_d   = '0;
                            state_d    = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                overrun_d = rx_ready;
                if (m_ready) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    if (rd_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        drop_count_d = pkt_drop_d ? sat_inc(drop_count_q) : drop_count_q;
    end

    always_comb begin
        buf_d = buf_q;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (buf_we && (wr_ptr_q == PW'(i))) begin
                buf_d[i] = rx_data;
            end
        end
    end

    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (rd_ptr_q == PW'(i)) begin
                rd_byte = buf_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            bad_q        <= 1'b0;
            pkt_good_q   <= 1'b0;
            pkt_drop_q   <= 1'b0;
            overrun_q    <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            bad_q        <= bad_d;
            pkt_good_q   <= pkt_good_d;
            pkt_drop_q   <= pkt_drop_d;
            overrun_q    <= overrun_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Payload storage needs no reset; it is only read after being written.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign m_valid    = (state_q == ST_DRAIN);
    assign m_data     = m_valid ? rd_byte : '0;
    assign m_last     = m_valid && rd_last;
    assign pkt_good   = pkt_good_q;
    assign pkt_drop   = pkt_drop_q;
    assign overrun    = overrun_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_rx_packet_assembler.sv
// Directed bench for the packet assembler with an output scoreboard and
// a negedge monitor for handshakes, stall stability and pulse exclusivity.
module tb_uart_rx_packet_assembler;

    localparam int unsigned MAX_LEN     = 16;
    localparam int unsigned TIMEOUT_CYC = 40;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        crc_valid;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        pkt_good;
    logic        pkt_drop;
    logic        overrun;
    logic [15:0] drop_count;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int n_good = 0;
    int n_drop = 0;
    int n_over = 0;
    int n_hs = 0;
    int n_valid_cyc = 0;

    logic       toggle_mode = 1'b0;
    logic       ready_level = 1'b1;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;
    logic       stall_last = 1'b0;

    uart_rx_packet_assembler #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .crc_valid  (crc_valid),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .pkt_good   (pkt_good),
        .pkt_drop   (pkt_drop),
        .overrun    (overrun),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_ready = toggle_mode ? ~m_ready : ready_level;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pkt_good) n_good++;
        if (pkt_drop) n_drop++;
        if (overrun)  n_over++;
        if (pkt_good || pkt_drop || overrun)
            check("pulse_excl", 32'(pkt_good) + 32'(pkt_drop) + 32'(overrun), 32'd1);
        if (m_valid) n_valid_cyc++;
        if (stall_prev && m_valid) begin
            check("stall_data", 32'(m_data), 32'(stall_data));
            check("stall_last", 32'(m_last), 32'(stall_last));
        end
        stall_prev = m_valid && !m_ready;
        stall_data = m_data;
        stall_last = m_last;
        if (m_valid && m_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_data", 32'(m_data), 32'(e.d));
                check("sb_last", 32'(m_last), 32'(e.l));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic c);
        rx_data   = d;
        rx_ready  = 1'b1;
        crc_valid = c;
        tick();
        rx_ready  = 1'b0;
        crc_valid = 1'b0;
        rx_data   = '0;
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc && m_valid; i++) tick();
        check("drain_done", 32'(m_valid), 32'd0);
    endtask

    task automatic check_quiet(input string tag, input logic [15:0] exp_cnt);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_pkt_good"}, 32'(pkt_good), 32'd0);
        check({tag, "_pkt_drop"}, 32'(pkt_drop), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_drop_count"}, 32'(drop_count), 32'(exp_cnt));
    endtask

    initial begin
        int hs0;
        int vc0;
        int ov0;
        int g0;
        exp_t e;

        reset     = 1'b0;
        rx_data   = '0;
        rx_ready  = 1'b0;
        crc_valid = 1'b0;
        repeat (3) tick();
        check_quiet("reset", 16'd0);
        reset = 1'b1;
        tick();

        // 1: clean 3-byte packet, back-to-back output
        e.d = 8'hA1; e.l = 1'b0; exp_q.push_back(e);
        e.d = 8'hB2; e.l = 1'b0; exp_q.push_back(e);
        e.d = 8'hC3; e.l = 1'b1; exp_q.push_back(e);
        send_byte(8'd3, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        check("t1_pkt_good", 32'(pkt_good), 32'd1);
        check("t1_valid0", 32'(m_valid), 32'd1);
        check("t1_data0", 32'(m_data), 32'hA1);
        check("t1_last0", 32'(m_last), 32'd0);
        tick();
        check("t1_data1", 32'(m_data), 32'hB2);
        check("t1_good_once", 32'(pkt_good), 32'd0);
        tick();
        check("t1_data2", 32'(m_data), 32'hC3);
        check("t1_last2", 32'(m_last), 32'd1);
        tick();
        check("t1_valid_end", 32'(m_valid), 32'd0);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t1_n_good", 32'(n_good), 32'd1);

        // 2: CRC error on payload byte 2
        vc0 = n_valid_cyc;
        send_byte(8'd3, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hC3, 1'b1);
        check("t2_pkt_drop", 32'(pkt_drop), 32'd1);
        check("t2_pkt_good", 32'(pkt_good), 32'd0);
        check("t2_drop_count", 32'(drop_count), 32'd1);
        repeat (3) tick();
        check("t2_no_valid", 32'(n_valid_cyc - vc0), 32'd0);

        // 3: bad headers, after a reset so drop_count restarts at 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        send_byte(8'd0, 1'b1);
        check("t3_drop_len0", 32'(pkt_drop), 32'd1);
        send_byte(8'(MAX_LEN + 1), 1'b1);
        check("t3_drop_long", 32'(pkt_drop), 32'd1);
        tick();
        check("t3_drop_count", 32'(drop_count), 32'd2);
        check("t3_idle_valid", 32'(m_valid), 32'd0);

        // 4: inter-byte timeout, then a 1-byte packet
        send_byte(8'd2, 1'b1);
        send_byte(8'h11, 1'b1);
        repeat (TIMEOUT_CYC - 1) tick();
        check("t4_no_early_drop", 32'(pkt_drop), 32'd0);
        tick();
        check("t4_timeout_drop", 32'(pkt_drop), 32'd1);
        check("t4_drop_count", 32'(drop_count), 32'd3);
        e.d = 8'h55; e.l = 1'b1; exp_q.push_back(e);
        send_byte(8'd1, 1'b1);
        send_byte(8'h55, 1'b1);
        check("t4_pkt_good", 32'(pkt_good), 32'd1);
        check("t4_data", 32'(m_data), 32'h55);
        check("t4_last", 32'(m_last), 32'd1);
        wait_drain(10);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: full-length packet with stalled sink and a byte mid-drain
        hs0 = n_hs;
        ov0 = n_over;
        send_byte(8'(MAX_LEN), 1'b1);
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            e.d = 8'(i * 13 + 5);
            e.l = (i == int'(MAX_LEN) - 1);
            exp_q.push_back(e);
            send_byte(e.d, 1'b1);
        end
        toggle_mode = 1'b1;
        check("t5_pkt_good", 32'(pkt_good), 32'd1);
        repeat (5) tick();
        send_byte(8'hEE, 1'b1);
        check("t5_overrun", 32'(overrun), 32'd1);
        wait_drain(200);
        toggle_mode = 1'b0;
        ready_level = 1'b1;
        tick();
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t5_hs_count", 32'(n_hs - hs0), 32'(MAX_LEN));
        check("t5_overrun_once", 32'(n_over - ov0), 32'd1);

        // 6: reset mid-COLLECT and mid-DRAIN
        g0 = n_good;
        send_byte(8'd3, 1'b1);
        send_byte(8'h10, 1'b1);
        reset = 1'b0;
        tick();
        check_quiet("t6_rst_collect", 16'd0);
        reset = 1'b1;
        ready_level = 1'b0;
        repeat (2) tick();
        send_byte(8'd2, 1'b1);
        send_byte(8'h21, 1'b1);
        send_byte(8'h22, 1'b1);
        check("t6_stalled_valid", 32'(m_valid), 32'd1);
        check("t6_stalled_data", 32'(m_data), 32'h21);
        tick();
        reset = 1'b0;
        tick();
        check_quiet("t6_rst_drain", 16'd0);
        reset = 1'b1;
        ready_level = 1'b1;
        repeat (2) tick();
        check("t6_no_pulse", 32'(n_good - g0), 32'd1);
        e.d = 8'h31; e.l = 1'b0; exp_q.push_back(e);
        e.d = 8'h32; e.l = 1'b1; exp_q.push_back(e);
        send_byte(8'd2, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        check("t6_pkt_good", 32'(pkt_good), 32'd1);
        wait_drain(10);
        tick();
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t6_drop_count", 32'(drop_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
